// File: rtl/mac_pkg.sv
// mac_pkg: shared MII lane codes, frame field sizes and receive sequencer state type.
package mac_pkg;
    localparam logic [7:0] IDLE_CODE     = 8'h07;
    localparam logic [7:0] START_CODE    = 8'hFB;
    localparam logic [7:0] TERM_CODE     = 8'hFD;
    localparam logic [7:0] PREAMBLE_CODE = 8'h55;
    localparam logic [7:0] SFD_CODE      = 8'hD5;
    localparam int DA_SIZE         = 6;
    localparam int SA_SIZE         = 6;
    localparam int LENGTH_TYPE     = 2;
    localparam int FCS_SIZE        = 4;
    localparam int MIN_FRAME_BYTES = 64;
    localparam int MAX_FRAME_BYTES = 1518;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, BODY, DROP} rx_seq_state_t;
endpackage

// File: rtl/mac_rx_frame_sequencer_if.sv
// mac_rx_frame_sequencer_if: lane-word input and per-frame status bundle.
interface mac_rx_frame_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 11
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic [CTRL_WIDTH-1:0] i_rx_ctrl;
    logic                  o_busy;
    logic                  o_frame_done;
    logic [CNT_WIDTH-1:0]  o_byte_count;
    logic [47:0]           o_dst_addr;
    logic [47:0]           o_src_addr;
    logic [15:0]           o_length_type;
    logic [31:0]           o_rx_fcs;
    logic                  o_preamble_error;
    logic                  o_length_error;
    logic                  o_ctrl_error;
    modport master (
        output i_rx_data, i_rx_ctrl,
        input  o_busy, o_frame_done, o_byte_count, o_dst_addr, o_src_addr, o_length_type,
        input  o_rx_fcs, o_preamble_error, o_length_error, o_ctrl_error
    );
    modport slave (
        input  i_rx_data, i_rx_ctrl,
        output o_busy, o_frame_done, o_byte_count, o_dst_addr, o_src_addr, o_length_type,
        output o_rx_fcs, o_preamble_error, o_length_error, o_ctrl_error
    );
endinterface

// File: rtl/mac_lane_ctrl_decode.sv
// mac_lane_ctrl_decode: finds the first control lane and classifies it as terminate with an idle tail.
module mac_lane_ctrl_decode
    import mac_pkg::*;
(
    input  logic [63:0] data,
    input  logic [7:0]  ctrl,
    output logic        has_ctrl,
    output logic [2:0]  first,
    output logic        is_term,
    output logic        tail_idle_ok
);
    always_comb begin
        has_ctrl = |ctrl;
        first = '0;
        for (int k = 7; k >= 0; k--)
            if (ctrl[k]) first = 3'(k);
        is_term = has_ctrl && data[8*first +: 8] == TERM_CODE;
        tail_idle_ok = 1'b1;
        for (int k = 0; k < 8; k++)
            if (k > int'(first) && !(ctrl[k] && data[8*k +: 8] == IDLE_CODE)) tail_idle_ok = 1'b0;
    end
endmodule

// File: rtl/mac_rx_frame_sequencer.sv
// mac_rx_frame_sequencer: splits the 8-lane MII stream into frames, captures header/FCS
// and strobes per-frame status one clock after the frame ends.
module mac_rx_frame_sequencer #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = 8,
    parameter int MIN_FRAME_SIZE = 64,
    parameter int MAX_FRAME_SIZE = 1518,
    parameter int CNT_WIDTH      = 11
) (
    input logic clk,
    input logic i_rst_n,
    mac_rx_frame_sequencer_if.slave bus
);
    import mac_pkg::*;
    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_FRAME_SIZE);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_FRAME_SIZE);
    localparam int SA_HI = 8 - DA_SIZE;
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic has_ctrl, is_term, tail_idle_ok;
    logic [2:0] first;
    rx_seq_state_t state;
    logic busy, done, pre_err, len_err, ctl_err;
    logic [CNT_WIDTH-1:0] count, cnt_next;
    logic [CNT_WIDTH:0] sum;
    logic [8*DA_SIZE-1:0] dst, dst_n;
    logic [8*SA_SIZE-1:0] src, src_n;
    logic [8*LENGTH_TYPE-1:0] lt, lt_n;
    logic [8*FCS_SIZE-1:0] fcs, fcs_n;
    logic [3:0] n;
    logic start, start_ok, all_idle, any_term;

    assign data = bus.i_rx_data;
    assign ctrl = bus.i_rx_ctrl;

    mac_lane_ctrl_decode u_decode (
        .data(data), .ctrl(ctrl), .has_ctrl(has_ctrl), .first(first),
        .is_term(is_term), .tail_idle_ok(tail_idle_ok)
    );

    // n = number of leading data lanes in this word (8 when there is no control lane)
    always_comb begin
        n = has_ctrl ? {1'b0, first} : 4'd8;
        sum = {1'b0, count} + (CNT_WIDTH+1)'(n);
        cnt_next = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        start = ctrl[0] && data[7:0] == START_CODE;
        start_ok = start && ctrl[7:1] == '0 && data[63:8] == {SFD_CODE, {6{PREAMBLE_CODE}}};
        all_idle = ctrl == '1 && data == {8{IDLE_CODE}};
        any_term = 1'b0;
        for (int k = 0; k < 8; k++)
            if (ctrl[k] && data[8*k +: 8] == TERM_CODE) any_term = 1'b1;
        fcs_n = fcs;
        for (int k = 0; k < 8; k++)
            if (k < int'(n)) fcs_n = {fcs_n[8*FCS_SIZE-9:0], data[8*k +: 8]};
        dst_n = dst;
        src_n = src;
        lt_n = lt;
        for (int k = 0; k < DA_SIZE; k++)
            if (state == HDR0 && k < int'(n)) dst_n[8*(DA_SIZE-1-k) +: 8] = data[8*k +: 8];
        for (int k = DA_SIZE; k < 8; k++)
            if (state == HDR0 && k < int'(n)) src_n[8*(SA_SIZE-1-(k-DA_SIZE)) +: 8] = data[8*k +: 8];
        for (int k = 0; k < SA_SIZE - SA_HI; k++)
            if (state == HDR1 && k < int'(n)) src_n[8*(SA_SIZE-1-(k+SA_HI)) +: 8] = data[8*k +: 8];
        for (int k = SA_SIZE - SA_HI; k < SA_SIZE - SA_HI + LENGTH_TYPE; k++)
            if (state == HDR1 && k < int'(n)) lt_n[8*(LENGTH_TYPE-1-(k-SA_SIZE+SA_HI)) +: 8] = data[8*k +: 8];
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pre_err <= 1'b0;
            len_err <= 1'b0;
            ctl_err <= 1'b0;
            count   <= '0;
            dst     <= '0;
            src     <= '0;
            lt      <= '0;
            fcs     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    count   <= '0;
                    dst     <= '0;
                    src     <= '0;
                    lt      <= '0;
                    fcs     <= '0;
                    len_err <= 1'b0;
                    ctl_err <= 1'b0;
                    pre_err <= !start_ok;
                    busy    <= 1'b1;
                    state   <= start_ok ? HDR0 : DROP;
                end
                HDR0, HDR1, BODY: if (!has_ctrl || is_term) begin
                    count <= cnt_next;
                    fcs   <= fcs_n;
                    dst   <= dst_n;
                    src   <= src_n;
                    lt    <= lt_n;
                    if (is_term) begin
                        ctl_err <= !tail_idle_ok;
                        len_err <= cnt_next < MIN_CNT || cnt_next > MAX_CNT;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= state == HDR0 ? HDR1 : BODY;
                    end
                end else begin
                    ctl_err <= 1'b1;
                    state   <= DROP;
                end
                DROP: if (any_term || all_idle) begin
                    len_err <= count < MIN_CNT || count > MAX_CNT;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_busy           = busy;
    assign bus.o_frame_done     = done;
    assign bus.o_byte_count     = count;
    assign bus.o_dst_addr       = dst;
    assign bus.o_src_addr       = src;
    assign bus.o_length_type    = lt;
    assign bus.o_rx_fcs         = fcs;
    assign bus.o_preamble_error = pre_err;
    assign bus.o_length_error   = len_err;
    assign bus.o_ctrl_error     = ctl_err;
endmodule

// File: tb/tb_mac_rx_frame_sequencer.sv
// tb_mac_rx_frame_sequencer: frames built as byte lists, encoded onto lanes; a scoreboard
// holds per-frame expectations derived from the byte list and a monitor checks each strobe.
module tb_mac_rx_frame_sequencer;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [10:0] cnt;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] lt;
        logic [31:0] fcs;
        logic pre, len, ctl;
    } exp_t;

    localparam logic [63:0] IDLE_WORD = {8{8'h07}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    mac_rx_frame_sequencer_if bus ();
    mac_rx_frame_sequencer dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Expected status straight from the frame's byte list and how it was mangled
    function automatic exp_t model(input bq_t b, input bit bad_pre, input int corrupt, input bit bad_tail);
        exp_t e;
        int nb;
        e = '{default: '0};
        if (bad_pre) begin
            e.pre = 1'b1;
            e.len = 1'b1;
            return e;
        end
        nb = corrupt >= 0 ? 8 * corrupt : b.size();
        e.cnt = nb > 2047 ? 11'd2047 : 11'(nb);
        for (int i = 0; i < nb && i < 14; i++)
            if (i < 6) e.dst[47-8*i -: 8] = b[i];
            else if (i < 12) e.src[47-8*(i-6) -: 8] = b[i];
            else e.lt[15-8*(i-12) -: 8] = b[i];
        for (int i = (nb > 4 ? nb - 4 : 0); i < nb; i++) e.fcs = {e.fcs[23:0], b[i]};
        e.len = nb < 64 || nb > 1518;
        e.ctl = corrupt >= 0 || bad_tail;
        return e;
    endfunction

    task automatic put(input logic [63:0] d, input logic [7:0] c);
        @(posedge clk);
        #1;
        bus.i_rx_data = d;
        bus.i_rx_ctrl = c;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) put(IDLE_WORD, 8'hFF);
    endtask

    task automatic send_frame(input bq_t b, input bit bad_pre, input int corrupt, input bit bad_tail);
        logic [63:0] d;
        logic [7:0] c;
        int full, r, cw;
        bit bt;
        full = b.size() / 8;
        r = b.size() % 8;
        cw = corrupt < full ? corrupt : -1;
        bt = bad_tail && r < 7 && cw < 0;
        sb.push_back(model(b, bad_pre, cw, bt));
        d = {8'hD5, {6{8'h55}}, 8'hFB};
        if (bad_pre) d[31:24] = 8'h54;
        put(d, 8'h01);
        for (int w = 0; w < full; w++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = b[8*w+k];
            if (w == cw) begin
                d[23:16] = 8'hFB;
                put(d, 8'h04);
                put(IDLE_WORD, 8'hFF);
                return;
            end
            put(d, 8'h00);
        end
        d = IDLE_WORD;
        c = 8'hFF;
        for (int k = 0; k < r; k++) begin
            d[8*k +: 8] = b[8*full+k];
            c[k] = 1'b0;
        end
        d[8*r +: 8] = 8'hFD;
        if (bt) d[8*(r+1) +: 8] = 8'h1C;
        put(d, c);
    endtask

    function automatic bq_t rand_bytes(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.o_frame_done), 64'd0);
        chk({tag, "_count"}, 64'(bus.o_byte_count), 64'd0);
        chk({tag, "_dst"}, 64'(bus.o_dst_addr), 64'd0);
        chk({tag, "_src"}, 64'(bus.o_src_addr), 64'd0);
        chk({tag, "_lt_fcs"}, {16'd0, bus.o_length_type, bus.o_rx_fcs}, 64'd0);
        chk({tag, "_errs"}, 64'({bus.o_preamble_error, bus.o_length_error, bus.o_ctrl_error}), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_frame_done) begin
                chk("done_one_cycle", 64'(prev_done), 64'd0);
                chk("busy_at_done", 64'(bus.o_busy), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got strobe count=%0d expected none", bus.o_byte_count);
                end else begin
                    e = sb.pop_front();
                    chk("byte_count", 64'(bus.o_byte_count), 64'(e.cnt));
                    chk("dst_addr", 64'(bus.o_dst_addr), 64'(e.dst));
                    chk("src_addr", 64'(bus.o_src_addr), 64'(e.src));
                    chk("length_type", 64'(bus.o_length_type), 64'(e.lt));
                    chk("rx_fcs", 64'(bus.o_rx_fcs), 64'(e.fcs));
                    chk("preamble_error", 64'(bus.o_preamble_error), 64'(e.pre));
                    chk("length_error", 64'(bus.o_length_error), 64'(e.len));
                    chk("ctrl_error", 64'(bus.o_ctrl_error), 64'(e.ctl));
                end
            end
            prev_done = bus.o_frame_done;
        end
    end

    initial begin : stim
        bq_t b;
        int len, full, cor;
        bus.i_rx_data = IDLE_WORD;
        bus.i_rx_ctrl = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h08, 8'h00};
        b = {b, rand_bytes(50)};
        send_frame(b, 0, -1, 0);
        idle(1);
        send_frame(rand_bytes(100), 0, -1, 0);
        send_frame(rand_bytes(30), 1, -1, 0);
        idle(1);
        send_frame(rand_bytes(20), 0, -1, 0);
        send_frame(rand_bytes(1600), 0, -1, 0);
        idle(2);
        send_frame(rand_bytes(2100), 0, -1, 0);
        send_frame(rand_bytes(0), 0, -1, 0);
        send_frame(rand_bytes(3), 0, -1, 0);
        send_frame(rand_bytes(10), 0, -1, 0);
        idle(1);
        send_frame(rand_bytes(200), 0, 5, 0);
        send_frame(rand_bytes(64), 0, -1, 0);
        send_frame(rand_bytes(70), 0, -1, 1);
        idle(2);
        put({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01);
        for (int i = 0; i < 4; i++) put({$urandom, $urandom}, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midframe_reset");
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(rand_bytes(77), 0, -1, 0);
        for (int t = 0; t < 14; t++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(60, 400);
            full = len / 8;
            cor = (full >= 3 && $urandom_range(0, 5) == 0) ? $urandom_range(2, full - 1) : -1;
            send_frame(rand_bytes(len), $urandom_range(0, 9) == 0, cor, $urandom_range(0, 5) == 0);
            idle($urandom_range(0, 2));
        end
        idle(2);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_strobes: got %0d frames unreported expected 0", sb.size());
        end
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_rx_frame_sequencer.md
Name: mac_rx_frame_sequencer

Overview:
- Receive-side controller between the 64-bit/8-lane MII lane stream and mac_checker.
- Parses lane data/control words into frame phases: start+preamble+SFD, header, body, terminate.
- Captures DA/SA/length-type and FCS, and counts frame bytes.
- Issues a one-cycle frame-done strobe with per-frame status, which the checker consumes as its data-valid.

Parameters:
- DATA_WIDTH, 64, lane-word data width (8 lanes x 8 bits)
- CTRL_WIDTH, 8, one control bit per lane
- MIN_FRAME_SIZE, 64, minimum bytes from DA through FCS inclusive
- MAX_FRAME_SIZE, 1518, maximum bytes from DA through FCS inclusive
- CNT_WIDTH, 11, byte counter width; saturates at 2^CNT_WIDTH-1

Ports:
- clk, input, 1, clock
- i_rst_n, input, 1, asynchronous active-low reset
- i_rx_data, input, DATA_WIDTH, lane word; lane k = bits [8k+7:8k]; lane 0 is first on the wire
- i_rx_ctrl, input, CTRL_WIDTH, bit k set means lane k carries a control code
- o_busy, output, 1, frame in progress (state not IDLE)
- o_frame_done, output, 1, one-cycle strobe; all status outputs valid while high
- o_byte_count, output, CNT_WIDTH, frame bytes from DA through FCS
- o_dst_addr, output, 48, DA; first byte in [47:40]
- o_src_addr, output, 48, SA; first byte in [47:40]
- o_length_type, output, 16, first byte in [15:8]
- o_rx_fcs, output, 32, last 4 frame bytes before terminate; first of the four in [31:24]
- o_preamble_error, output, 1, start word malformed
- o_length_error, output, 1, byte count < MIN or > MAX
- o_ctrl_error, output, 1, unexpected control code inside a frame

Behaviour:
- Reset: all outputs 0, state IDLE, counters and capture registers cleared. Reset mid-frame discards the frame; no strobe is issued.
- States: IDLE, HDR0, HDR1, BODY, DROP. All outputs are registered.
- IDLE:
  - Start detection: ctrl[0]=1 and lane0=FB.
  - Start word correct: lanes1-6=55, lane7=D5, ctrl[7:1]=0. Go to HDR0.
  - Start seen but word incorrect: latch preamble_error and go to DROP.
  - Any other word: stay in IDLE.
- HDR0:
  - With ctrl=0: DA = lanes0-5, SA[47:32] = lanes6-7, count += 8, go to HDR1.
- HDR1:
  - With ctrl=0: SA[31:0] = lanes0-3, length_type = lanes4-5, count += 8, go to BODY.
- BODY: each ctrl=0 word adds 8 to the count and shifts all 8 bytes into the FCS history register.
- Terminate word, in HDR0/HDR1/BODY:
  - t = lowest lane with ctrl set. If that lane is FD, it is a terminate.
  - Lanes <t are data: count += t, and those lanes shift into the FCS history.
  - Lanes >t must be ctrl=1 with value 07; otherwise set ctrl_error.
  - Go to IDLE and pulse o_frame_done the next cycle (latency 1 clock after the terminate word).
  - A terminate in HDR0/HDR1 yields a short frame and length_error. DA/SA/length_type capture only the bytes received.
- Non-FD control lane inside a frame (including FB): set ctrl_error and go to DROP. A new start inside a frame is not accepted.
- DROP:
  - Wait for a word containing FD, or an all-idle word (ctrl=FF, all lanes 07).
  - Then pulse o_frame_done with the latched errors and go to IDLE.
- Start word arriving in the same cycle frame_done is pulsed: accepted normally.
- Length check at done: length_error = (count < MIN_FRAME_SIZE) or (count > MAX_FRAME_SIZE).
  - The counter saturates and never wraps.
  - An oversize frame keeps counting until terminate; no early abort.
- o_rx_fcs = 4 most recent frame bytes. Defined only if count >= 4; otherwise holds the shifted-in bytes, zero-filled.
- Error flags and capture registers:
  - Cleared on frame-start acceptance.
  - Otherwise held after done until the next start.
  - o_frame_done is high for exactly one cycle.

Decomposition:
- Shared package mac_pkg:
  - Codes IDLE_CODE, START_CODE, TERM_CODE, PREAMBLE_CODE, SFD_CODE.
  - Field sizes DA_SIZE=6, SA_SIZE=6, LENGTH_TYPE=2, FCS_SIZE=4.
  - MIN/MAX frame sizes; state enum rx_seq_state_t.
  - mac_checker also imports these.
- One combinational sub-module, mac_lane_ctrl_decode:
  - Inputs: data and ctrl.
  - Outputs: has_ctrl, first control lane index (3 bits), is_term, tail_idle_ok.

Test Plan:
- Minimum frame:
  - Stimulus: start word 64'hD5555555555555FB / ctrl 01; 8 data words (DA FF..FF, SA 12 34 56 78 9A BC, LT 0800); then data 64'h07070707070707FD / ctrl FF.
  - Response: one strobe, count=64, dst=FFFFFFFFFFFF, src=123456789ABC, length_type=0800, all errors 0.
- Mid-lane terminate:
  - Stimulus: 100-byte frame ending with FD in lane 4, ctrl F0.
  - Response: count=100; o_rx_fcs = lanes0-3 of the last word (terminate word); no ctrl_error.
- Bad preamble:
  - Stimulus: start word with lane3=54.
  - Response: preamble_error=1 strobe after the terminate word, no header capture.
- Runt and giant frames:
  - Stimulus: 20-byte frame; separately a 1600-byte frame.
  - Response: length_error=1 for both; counts 20 and 1600.
- Control corruption:
  - Stimulus: FB in lane 2 of a body word, ctrl 04.
  - Response: ctrl_error=1; sequencer in DROP until an all-idle word, then strobe, then accepts a back-to-back good frame.
- Reset mid-frame:
  - Stimulus: i_rst_n low during BODY.
  - Response: outputs 0 immediately, no strobe; the next good frame is processed normally.
